// File: rtl/muldiv_pkg.sv
// Shared encodings and arithmetic helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'b00,
    MULDIV_MULTU = 2'b01,
    MULDIV_DIV   = 2'b10,
    MULDIV_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } muldiv_state_e;

  localparam int MULDIV_DIV_ITERS = 32;

  // Low 64 bits of the product of the operands extended to 64 bits: correct for both signednesses.
  function automatic logic [63:0] mul64(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] abs32(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Unsigned radix-2 restoring divider datapath: load once, then one quotient bit per step.
module div_radix2_core (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dsr;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_ge;

  // Remainder stays below the divisor, so the shifted trial value always fits in 33 bits.
  assign w_trial = {r_rem, r_quo[31]};
  assign w_diff  = w_trial - {1'b0, r_dsr};
  assign w_ge    = ~w_diff[32];

  always_ff @(posedge clk) begin
    if (load) begin
      r_quo <= dividend;
      r_rem <= 32'd0;
      r_dsr <= divisor;
    end else if (step) begin
      r_rem <= w_ge ? w_diff[31:0] : w_trial[31:0];
      r_quo <= {r_quo[30:0], w_ge};
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/muldiv_seq.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer: stalls EX while busy, holds hilo with done until pipe_ack.
// Latency: mul MUL_CYCLES, div DIV_ITERS+2, div-by-zero 1; MULDIV_EARLY_OUT_EN lets |a|<|b| divides finish at 1.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = MULDIV_DIV_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_op_valid,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  input  logic        i_pipe_ack,
  output logic        o_stall,
  output logic        o_done,
  output logic [63:0] o_hilo,
  output logic        o_div_by_zero
);

  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(DIV_ITERS - 1);

  muldiv_state_e r_state;
  logic [7:0]    r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_sgn;
  logic          r_neg_q;
  logic          r_neg_r;
  logic [63:0]   r_hilo;
  logic          r_dbz;

  muldiv_op_e    w_op;
  logic          w_sgn;
  logic          w_is_div;
  logic          w_b_zero;
  logic [31:0]   w_abs_a;
  logic [31:0]   w_abs_b;
  logic          w_early;
  logic          w_div_load;
  logic          w_div_step;
  logic [31:0]   w_quo;
  logic [31:0]   w_rem;
  logic [31:0]   w_quo_fix;
  logic [31:0]   w_rem_fix;

  assign w_op     = muldiv_op_e'(i_op);
  assign w_sgn    = (w_op == MULDIV_MULT) || (w_op == MULDIV_DIV);
  assign w_is_div = (w_op == MULDIV_DIV) || (w_op == MULDIV_DIVU);
  assign w_b_zero = (i_b == 32'd0);
  assign w_abs_a  = abs32(w_sgn, i_a);
  assign w_abs_b  = abs32(w_sgn, i_b);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  assign w_div_load = (r_state == IDLE) && i_op_valid && !i_flush && w_is_div && !w_b_zero;
  assign w_div_step = (r_state == DIV);

  div_radix2_core u_div (
    .clk       (clk),
    .load      (w_div_load),
    .step      (w_div_step),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // Quotient sign follows sign(a)^sign(b); remainder follows sign(a).
  assign w_quo_fix = r_neg_q ? (~w_quo + 32'd1) : w_quo;
  assign w_rem_fix = r_neg_r ? (~w_rem + 32'd1) : w_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hilo  <= 64'd0;
      r_dbz   <= 1'b0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_op_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sgn   <= w_sgn;
            r_neg_q <= w_sgn & (i_a[31] ^ i_b[31]);
            r_neg_r <= w_sgn & i_a[31];
            if (!w_is_div) begin
              r_cnt <= 8'd1;
              if (MUL_CYCLES <= 1) begin
                r_hilo  <= mul64(w_sgn, i_a, i_b);
                r_dbz   <= 1'b0;
                r_state <= DONE;
              end else begin
                r_state <= MUL;
              end
            end else if (w_b_zero) begin
              r_hilo  <= {i_a, 32'hFFFF_FFFF};
              r_dbz   <= 1'b1;
              r_state <= DONE;
            end else if (w_early) begin
              r_hilo  <= {i_a, 32'd0};
              r_dbz   <= 1'b0;
              r_state <= DONE;
            end else begin
              r_cnt   <= 8'd0;
              r_state <= DIV;
            end
          end
        end
        MUL: begin
          if (r_cnt == MUL_LAST) begin
            r_hilo  <= mul64(r_sgn, r_a, r_b);
            r_dbz   <= 1'b0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DIV: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        FIX: begin
          r_hilo  <= {w_rem_fix, w_quo_fix};
          r_dbz   <= 1'b0;
          r_state <= DONE;
        end
        DONE: begin
          if (i_pipe_ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_stall = !i_flush &&
                   (((r_state == IDLE) && i_op_valid) ||
                    (r_state == MUL) || (r_state == DIV) || (r_state == FIX));
  assign o_done        = (r_state == DONE) && !i_flush;
  assign o_hilo        = r_hilo;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized + directed bench for muldiv_seq against a plain-arithmetic reference model.
module tb_muldiv_seq;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_ITERS  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        pipe_ack;
  logic        stall;
  logic        done;
  logic [63:0] hilo;
  logic        dbz;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] last_hilo;

  always #5 clk = ~clk;

  muldiv_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_ITERS  (DIV_ITERS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_op_valid    (op_valid),
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .i_flush       (flush),
    .i_pipe_ack    (pipe_ack),
    .o_stall       (stall),
    .o_done        (done),
    .o_hilo        (hilo),
    .o_div_by_zero (dbz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic (truncating division, remainder sign of dividend).
  function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [63:0] hl, output logic dz, output int lat);
    longint sa, sb, q, r;
    bit sgn;
    sgn = !mop[0];
    sa  = sgn ? longint'($signed(ma)) : longint'(ma);
    sb  = sgn ? longint'($signed(mb)) : longint'(mb);
    dz  = 1'b0;
    if (!mop[1]) begin
      hl  = sa * sb;
      lat = MUL_CYCLES;
    end else if (mb == 32'd0) begin
      hl  = {ma, 32'hFFFF_FFFF};
      dz  = 1'b1;
      lat = 1;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      hl  = {r[31:0], q[31:0]};
      lat = DIV_ITERS + 2;
`ifdef MULDIV_EARLY_OUT_EN
      if (((sa < 0) ? -sa : sa) < ((sb < 0) ? -sb : sb)) lat = 1;
`endif
    end
  endfunction

  // Issue one op from IDLE, follow it to DONE, hold it `hold` cycles, then retire (ack or flush).
  task automatic run_op(input logic [1:0] top, input logic [31:0] ta, input logic [31:0] tb,
                        input int hold, input bit flush_end);
    logic [63:0] exp_hl;
    logic        exp_dz;
    int          exp_lat;
    int          cyc;
    bit          got_done;
    model(top, ta, tb, exp_hl, exp_dz, exp_lat);
    @(negedge clk);
    op_valid = 1'b1; op = top; a = ta; b = tb; flush = 1'b0; pipe_ack = 1'b0;
    #1;
    chk("stall_accept", stall, 1'b1);
    chk("done_accept", done, 1'b0);
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      #1;
      if (done) got_done = 1'b1;
      else chk("stall_busy", stall, 1'b1);
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("hilo", hilo, exp_hl);
    chk("div_by_zero", dbz, exp_dz);
    chk("stall_in_done", stall, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk("done_held", done, 1'b1);
      chk("hilo_held", hilo, exp_hl);
      chk("dbz_held", dbz, exp_dz);
    end
    @(negedge clk);
    pipe_ack = 1'b1;
    flush = flush_end;
    #1;
    chk("done_at_retire", done, !flush_end);
    chk("stall_at_retire", stall, 1'b0);
    @(negedge clk);
    op_valid = 1'b0; pipe_ack = 1'b0; flush = 1'b0;
    #1;
    chk("idle_stall", stall, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_hilo", hilo, exp_hl);
    last_hilo = exp_hl;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; op_valid = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    flush = 1'b0; pipe_ack = 1'b0; last_hilo = 64'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hilo", hilo, 64'd0);
    chk("rst_dbz", dbz, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b10, 32'h0000_1234, 32'd0, 2, 1'b0);

    // DIVU killed at cycle 10, then a MULTU accepted immediately after.
    @(negedge clk);
    op_valid = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    #1;
    chk("fl_stall_c0", stall, 1'b1);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("fl_stall_busy", stall, 1'b1);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall, 1'b0);
    chk("fl_done", done, 1'b0);
    chk("fl_hilo_kept", hilo, last_hilo);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);

    run_op(2'b01, 32'd3, 32'd5, 3, 1'b0);
    run_op(2'b00, 32'h1234_5678, 32'h8765_4321, 1, 1'b1);
    run_op(2'b10, 32'hFFFF_FF00, 32'd7, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = $urandom;
        default: rb = 32'hFFFF_FFFF;
      endcase
      if ($urandom_range(0, 4) == 0) ra = $urandom_range(0, 15);
      run_op(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a divide.
    @(negedge clk);
    op_valid = 1'b1; op = 2'b10; a = 32'h7654_3210; b = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_hilo", hilo, 64'd0);
    chk("rst_mid_dbz", dbz, 1'b0);
    run_op(2'b11, 32'hDEAD_BEEF, 32'd1000, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer for the EX-stage HI/LO arithmetic: MULT, MULTU, DIV, DIVU.
- Accepts one operation from EX and runs a pipelined multiplier or an iterative radix-2 restoring divider.
- Holds EX with `stall` while busy, then presents a 64-bit `hilo` with a `done` qualifier.
- Cancels cleanly on pipeline flush.

Parameters:
- MUL_CYCLES, 2: multiplier latency in cycles, accept to done; minimum 1.
- DIV_ITERS, 32: divider iteration count; fixed to the operand width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  EX holds a HI/LO arithmetic instruction
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  operand rs (already forwarded)
- b  in  32  operand rt (already forwarded)
- flush  in  1  exception or eret; kill the in-flight operation
- pipe_ack  in  1  EX->MEM register advances this cycle
- stall  out  1  hold IF/ID/EX
- done  out  1  hilo valid this cycle
- hilo  out  64  {HI, LO}
- div_by_zero  out  1  qualifies done for a divide whose b==0

Behaviour:
- Reset: state IDLE; stall=0, done=0, hilo=0, div_by_zero=0; counter, operand and result registers cleared.
- States:
  - IDLE: op_valid && !flush latches a, b, op and sign info. Goes to MUL, or DIV when b!=0, or DONE when b==0 on a divide.
  - MUL: counter counts up to MUL_CYCLES-1. When reached, registers the product and goes to DONE.
  - DIV: one restoring iteration per cycle for DIV_ITERS cycles, on absolute values for signed ops. Then one FIX cycle goes to DONE.
  - FIX: applies signs. Quotient is negated iff signs of a and b differ. Remainder takes the sign of a.
  - DONE: done=1. Stays while !pipe_ack; on pipe_ack goes to IDLE.
- stall:
  - Combinational: (op_valid in IDLE) or state in {MUL, DIV, FIX}, gated by !flush.
  - 0 in DONE, so EX may advance.
- Latency, with the accept cycle counted as 0:
  - MUL/MULTU: done at cycle MUL_CYCLES.
  - DIV/DIVU: done at cycle DIV_ITERS+2, i.e. 34 at default.
  - Divide by zero: done at cycle 1.
- Arithmetic:
  - MULT: 64-bit two's-complement product.
  - MULTU: unsigned product.
  - HI=remainder, LO=quotient.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
  - Divide by zero: hilo={a, 32'hFFFF_FFFF}, div_by_zero=1 with done.
- hilo and div_by_zero hold stable throughout DONE. Both keep their last value when not done; only done qualifies them.
- In DONE, op_valid is ignored: it is the same instruction. A new operation is accepted only from IDLE.
- flush (any state): next state IDLE. done and stall are forced 0 in the flush cycle. Partial results are discarded, and hilo keeps its previous committed value.
- flush and pipe_ack in the same DONE cycle: flush wins; IDLE, done forced 0.
- rst mid-operation: immediate return to reset values on the next edge.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, a divide with b!=0 and |a| < |b| (unsigned compare for DIVU) skips DIV/FIX.
  - Goes to DONE at cycle 1 with LO=0, HI=a.
- Undefined: every nonzero divide takes the full DIV_ITERS+2 cycles.

Decomposition:
- Package muldiv_pkg:
  - op encoding typedef (MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU).
  - state enum (IDLE, MUL, DIV, FIX, DONE).
  - DIV_ITERS default constant.
- Sub-module div_radix2_core:
  - Holds the 32-bit remainder/quotient shift registers and one-iteration subtract.
  - Ports: clk, load, step, dividend, divisor, quotient, remainder.
- Multiplier pipeline and sign handling stay in muldiv_seq.

Test Plan:
- MULT a=0xFFFFFFFD, b=7 -> stall cycles 0..1; done at cycle 2; hilo=0xFFFFFFFF_FFFFFFEB.
- DIVU a=100, b=7 -> stall cycles 0..33; done at cycle 34; HI=2, LO=0x0000000E.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV a=0x1234, b=0 -> done at cycle 1; hilo=0x00001234_FFFFFFFF; div_by_zero=1.
- DIVU flushed at cycle 10 -> stall=0 and done=0 that cycle; IDLE next; MULTU 0xFFFFFFFF*2 accepted next cycle -> hilo=0x00000001_FFFFFFFE.
- MULTU 3*5 with pipe_ack low for 3 DONE cycles -> done=1 and hilo=0x0000000F held for 3 cycles; IDLE after pipe_ack.
